// File: rtl/uart_pkg.sv
// uart_pkg: types and helpers shared by the UART driver and the UART decoder.
// Holds the line-state enum, the data width and the clock-to-baud divisor.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Integer clock cycles per bit. The remainder is truncated.
    function automatic int uart_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_driver_if.sv
// uart_driver_if: valid/ready byte port feeding the UART driver FIFO.
// The master offers bytes. The slave accepts a byte on any cycle where
// in_valid && in_ready.
interface uart_driver_if;
    import uart_pkg::*;

    logic                      in_valid;
    logic [UART_DATA_BITS-1:0] in_data;
    logic                      in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/uart_driver_fifo.sv
// uart_fifo: synchronous DEPTH x 8 FIFO with a registered occupancy count.
// The read data is combinational from the head entry, so a pop captures the
// byte on the same edge that advances the read pointer.
// DEPTH must be a power of two, so the pointers wrap on their own.
module uart_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [7:0]                 wr_data,
    input  logic                       pop,
    output logic [7:0]                 rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Advance the pointers and track occupancy. A push and a pop on the same cycle cancel out.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so that every flop samples pre-edge values.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Write the storage array.
    always_ff @(posedge clk) begin
        // NOTE: the array is not reset. The pointers and count define validity, so the array can map to plain RAM.
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_driver.sv
// uart_driver: FIFO-buffered UART transmitter producing 8N1 frames, LSB first.
// Define UART_DRIVER_PARITY_EN to add an even-parity bit (8E1 frames).
// Reset is synchronous and active high. A frame cut short by reset is dropped.
// uart_rx and frame_done are registered one cycle behind the FSM state.
module uart_driver
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int DEPTH         = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    uart_driver_if.slave               in_if,
    output logic                       uart_rx,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       frame_done
);

    localparam int              DIV      = uart_div(CLK_FREQUENCY, BAUD_RATE);
    localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]      BIT_LAST = 3'(UART_DATA_BITS - 1);

    uart_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_d;
    logic             done_d;
    logic             pop;
    logic             bit_end;
    logic [7:0]       fifo_rd_data;
    logic             fifo_full;
    logic             fifo_empty;
`ifdef UART_DRIVER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    uart_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (in_if.in_valid),
        .wr_data (in_if.in_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign in_if.in_ready = !fifo_full && !reset;
    assign busy           = (state_q != IDLE) || (fifo_count != '0);
    assign bit_end        = (cnt_q == CNT_LAST);

    // Next-state logic for the frame FSM. Also computes the next line level, the done pulse and the FIFO pop.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a variable unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_d    = 1'b1;
        done_d  = 1'b0;
        pop     = 1'b0;
`ifdef UART_DRIVER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
`ifdef UART_DRIVER_PARITY_EN
                    parity_d = ^fifo_rd_data;
`endif
                    state_d = START;
                end
            end
            START: begin
                rx_d = 1'b0;
                if (bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                rx_d = shift_q[0];
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_DRIVER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_DRIVER_PARITY_EN
            PARITY: begin
                rx_d = parity_q;
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                rx_d = 1'b1;
                if (bit_end) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
`ifdef UART_DRIVER_PARITY_EN
                        parity_d = ^fifo_rd_data;
`endif
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register the FSM state, counters, shift register and the line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            uart_rx    <= 1'b1;
            frame_done <= 1'b0;
`ifdef UART_DRIVER_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            uart_rx    <= rx_d;
            frame_done <= done_d;
`ifdef UART_DRIVER_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_driver.sv
// tb_uart_driver: directed and random bursts for uart_driver.
// Each burst is checked cycle by cycle against a frame-level model.
// An independent mid-bit serial decoder checks the byte stream end to end.
// A 1 Mbaud line (DIV = 50) keeps the run short.
module tb_uart_driver;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 1_000_000;
    localparam int DEPTH  = 16;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_DRIVER_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * DIV;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic       busy;
    logic       frame_done;
    logic [4:0] fifo_count;

    uart_driver_if drv ();

    uart_driver #(
        .CLK_FREQUENCY (CLK_HZ),
        .BAUD_RATE     (BAUD),
        .DEPTH         (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (drv),
        .uart_rx    (uart_rx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .frame_done (frame_done)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s (cycle %0d): observed 0x%0h, expected 0x%0h", tag, k, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] burst_q[$];
    logic [7:0] exp_log[$];

    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
`ifdef UART_DRIVER_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // k = cycles after the edge that accepted the first byte of the burst.
    function automatic logic line_at(input int k);
        int t;
        if (k < 2) return 1'b1;
        t = k - 2;
        if (t >= burst_q.size() * FRAME) return 1'b1;
        return frame_bit(burst_q[t / FRAME], (t % FRAME) / DIV);
    endfunction

    function automatic logic done_at(input int k);
        if (k < 2) return 1'b0;
        return ((k - 2) % FRAME == FRAME - 1) && ((k - 2) / FRAME < burst_q.size());
    endfunction

    function automatic logic busy_at(input int k);
        return k < 1 + burst_q.size() * FRAME;
    endfunction

    function automatic int count_at(input int k);
        int f_n = burst_q.size();
        int pushes = (k + 1 < f_n) ? k + 1 : f_n;
        int pops = 0;
        if (k >= 1) pops = ((k - 1) / FRAME + 1 < f_n) ? (k - 1) / FRAME + 1 : f_n;
        return pushes - pops;
    endfunction

    // ---------------- independent serial decoder ----------------
    logic [7:0]  rx_log[$];
    int          frame_errs = 0;
    bit          m_active = 0;
    int          m_t;
    int          m_idx;
    logic [10:0] m_bits;

    always begin
        @(posedge clk);
        #2;
        if (reset) begin
            m_active = 0;
        end else if (!m_active) begin
            if (uart_rx == 1'b0) begin
                m_active = 1;
                m_t = 0;
            end
        end else begin
            m_t++;
            if (m_t >= DIV / 2 && (m_t - DIV / 2) % DIV == 0) begin
                m_idx = (m_t - DIV / 2) / DIV;
                m_bits[m_idx] = uart_rx;
                if (m_idx == FRAME_BITS - 1) begin
                    m_active = 0;
`ifdef UART_DRIVER_PARITY_EN
                    if (m_bits[0] !== 1'b0 || uart_rx !== 1'b1 || m_bits[9] !== ^m_bits[8:1]) frame_errs++;
`else
                    if (m_bits[0] !== 1'b0 || uart_rx !== 1'b1) frame_errs++;
`endif
                    else rx_log.push_back(m_bits[8:1]);
                end
            end
        end
    end

    // Push burst_q on consecutive cycles and check every cycle until the line settles.
    task automatic run_burst();
        int f_n = burst_q.size();
        int total = 2 + f_n * FRAME + 3;
        @(negedge clk);
        check("pre_busy", -1, busy, 0);
        check("pre_ready", -1, drv.in_ready, 1);
        drv.in_valid = 1'b1;
        drv.in_data  = burst_q[0];
        @(posedge clk);
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            check("uart_rx", k, uart_rx, line_at(k));
            check("frame_done", k, frame_done, done_at(k));
            check("busy", k, busy, busy_at(k));
            check("fifo_count", k, fifo_count, count_at(k));
            check("in_ready", k, drv.in_ready, count_at(k) != DEPTH);
            if (k + 1 < f_n) drv.in_data = burst_q[k+1];
            else drv.in_valid = 1'b0;
        end
        foreach (burst_q[i]) exp_log.push_back(burst_q[i]);
    endtask

    initial begin
        logic [7:0] big_q[$];
        int         sent;
        int         k;
        int         drop_k;
        int         drop_cnt;
        bit         accept;
        int         n;

        reset        = 1'b1;
        drv.in_valid = 1'b0;
        drv.in_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_uart_rx", -1, uart_rx, 1);
        check("rst_busy", -1, busy, 0);
        check("rst_fifo_count", -1, fifo_count, 0);
        check("rst_frame_done", -1, frame_done, 0);
        check("rst_in_ready", -1, drv.in_ready, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", -1, drv.in_ready, 1);

        // Single 0x55 frame from idle.
        burst_q = '{8'h55};
        run_burst();
        // Back-to-back 0x00, 0xFF with no idle gap.
        burst_q = '{8'h00, 8'hFF};
        run_burst();
        burst_q = '{8'hC3};
        run_burst();
`ifdef UART_DRIVER_PARITY_EN
        burst_q = '{8'hA5, 8'h01};
        run_burst();
`endif
        // Random bursts.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 4);
            burst_q.delete();
            for (int i = 0; i < n; i++) burst_q.push_back(8'($urandom));
            run_burst();
        end

        // 20 random bytes with in_valid held high: back-pressure once 16 are queued.
        for (int i = 0; i < 20; i++) big_q.push_back(8'($urandom));
        sent = 0;
        k = 0;
        drop_k = -1;
        drop_cnt = -1;
        @(negedge clk);
        drv.in_valid = 1'b1;
        drv.in_data  = big_q[0];
        while (sent < 20 && k < 30 * FRAME) begin
            accept = drv.in_ready;
            if (!drv.in_ready && drop_k < 0) begin
                drop_k = k;
                drop_cnt = int'(fifo_count);
            end
            @(posedge clk);
            if (accept) sent++;
            @(negedge clk);
            k++;
            if (sent < 20) drv.in_data = big_q[sent];
            else drv.in_valid = 1'b0;
        end
        drv.in_valid = 1'b0;
        check("burst20_sent", k, sent, 20);
        check("burst20_drop_cycle", drop_k, drop_k, 17);
        check("burst20_drop_count", drop_k, drop_cnt, DEPTH);
        for (int i = 0; i < 25 * FRAME && busy; i++) @(negedge clk);
        check("burst20_idle", -1, busy, 0);
        repeat (4) @(negedge clk);
        foreach (big_q[i]) exp_log.push_back(big_q[i]);

        // Reset mid-DATA of 0xA5 with three bytes queued behind it.
        @(negedge clk);
        drv.in_valid = 1'b1;
        drv.in_data  = 8'hA5;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv.in_data = 8'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        drv.in_valid = 1'b0;
        check("rst_mid_queued", -1, fifo_count, 3);
        repeat (3 * DIV) @(negedge clk);
        check("rst_mid_busy_before", -1, busy, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_in_ready", -1, drv.in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_uart_rx", -1, uart_rx, 1);
        check("rst_mid_fifo_count", -1, fifo_count, 0);
        check("rst_mid_busy", -1, busy, 0);
        check("rst_mid_frame_done", -1, frame_done, 0);
        #1;
        check("rst_mid_ready_after", -1, drv.in_ready, 1);
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            check("rst_mid_line_held", i, {uart_rx, frame_done, busy}, 3'b100);
        end
        burst_q = '{8'h3C};
        run_burst();

        // End-to-end decoded byte stream.
        repeat (4) @(negedge clk);
        check("decoder_frame_errs", -1, frame_errs, 0);
        check("decoder_count", -1, rx_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < rx_log.size(); i++)
            check("decoder_byte", i, rx_log[i], exp_log[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_driver.md
# uart_driver

Simulation-side UART transmitter that drives the SoC's `serial_rx` line, covering the host-to-SoC direction that the bench-side UART decoder does not. The bench enqueues bytes through a valid/ready port into a small FIFO, and the block serialises them LSB-first as 8N1 frames at a fixed baud derived from the bench clock. It sits in the top-level testbench beside the UART decoder, clocked from `clk50`. It is written as synthesizable RTL so it can also be reused on-board as a loopback stimulus source.

## Interface
- `CLK_FREQUENCY`, 50_000_000, input clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `DEPTH`, 16, FIFO depth in bytes; must be a power of two and ≥2.
- `clk`  input  1  single clock for the whole block.
- `reset`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  bench offers `in_data`.
- `in_data`  input  8  byte to transmit.
- `in_ready`  output  1  byte accepted on a cycle where `in_valid && in_ready`.
- `uart_rx`  output  1  serial line to the SoC `serial_rx`; idles high.
- `busy`  output  1  high while a frame is on the line or the FIFO is non-empty.
- `fifo_count`  output  $clog2(DEPTH+1)  number of bytes queued, not counting the frame in flight.
- `frame_done`  output  1  one-cycle pulse on the last cycle of each stop bit.

## Operation
- Divisor `DIV = CLK_FREQUENCY / BAUD_RATE`, using integer truncation (434 at the defaults).
- The bit counter counts 0..DIV-1. Every bit lasts exactly DIV cycles.
- FSM states: IDLE, START, DATA, PARITY (present only when compiled in), STOP.
- IDLE:
  - `uart_rx`=1.
  - If the FIFO is non-empty: pop one byte into the shift register and go to START.
- START:
  - `uart_rx`=0 for DIV cycles, then go to DATA.
- DATA:
  - `uart_rx` = shift[0].
  - Shift right every DIV cycles.
  - After 8 bits, go to PARITY if it is enabled, otherwise to STOP.
- STOP:
  - `uart_rx`=1 for DIV cycles.
  - On the last cycle, pulse `frame_done`.
  - If the FIFO is non-empty on that cycle, pop and go directly to START (zero idle gap). Otherwise go to IDLE.
- `in_ready` = !full && !reset.
- Push while full is impossible. A push and a pop in the same cycle leave `fifo_count` unchanged.
- Pop happens only from IDLE or the last STOP cycle, and never when the FIFO is empty.
- `busy` = (state != IDLE) || (fifo_count != 0).
- Reset, including mid-frame, immediately (next edge) sets:
  - state = IDLE
  - `uart_rx`=1
  - FIFO emptied, `fifo_count`=0
  - bit counter = 0
  - `frame_done`=0
  - `busy`=0
- A truncated frame is therefore never completed.

## Timing
- `uart_rx` is registered.
- Byte pushed into an empty FIFO with the FSM in IDLE at edge N:
  - pop at edge N+1;
  - `uart_rx` falls at edge N+2.
- Frame length is 10·DIV cycles (11·DIV with parity).
- Back-to-back frames: the next start bit begins on the cycle immediately after the final stop cycle.
- `fifo_count` updates one cycle after the push or pop edge.
- `in_ready` deasserts in the cycle that `fifo_count` reaches DEPTH.

## Configuration
- Macro `UART_DRIVER_PARITY_EN`.
- Defined:
  - The PARITY state is present and drives the even-parity bit (XOR of the 8 data bits) for DIV cycles between DATA and STOP.
  - Frame is 8E1, 11·DIV cycles.
- Undefined:
  - No PARITY state exists.
  - Frame is 8N1, 10·DIV cycles. This is the default and matches the SoC UART.

## Structure
- Shared package `uart_pkg`, also used by the UART decoder:
  - state enum `uart_state_t` (IDLE, START, DATA, PARITY, STOP);
  - function `uart_div(clk_hz, baud)`;
  - constant `UART_DATA_BITS = 8`.
- One sub-module, `uart_fifo`:
  - synchronous FIFO of DEPTH × 8;
  - registered count; full/empty flags.
- The FSM, bit counter and shift register stay in `uart_driver`.

## Test plan
- Push 0x55 from IDLE at the defaults. Required response:
  - `uart_rx` low 434 cycles, then bits 1,0,1,0,1,0,1,0 at 434 cycles each, then high 434 cycles;
  - `frame_done` pulses once, at 4340 cycles after the falling edge minus 1.
- Push 0x00 then 0xFF on consecutive cycles:
  - one contiguous 8680-cycle waveform with no idle gap;
  - `fifo_count` goes 1→0 as the second byte is popped;
  - `busy` falls with the final stop bit.
- Push 20 bytes with `in_valid` held high:
  - `in_ready` drops once 16 bytes are queued behind the in-flight frame;
  - no byte is lost or duplicated;
  - the UART decoder reports all 20 bytes in order.
- Assert `reset` for one cycle mid-DATA of 0xA5 with 3 bytes queued:
  - next cycle `uart_rx`=1, `fifo_count`=0, `busy`=0;
  - a following push of 0x3C is transmitted correctly.
- With `UART_DRIVER_PARITY_EN` defined:
  - 0xA5 gives parity bit 0 and 0x01 gives parity bit 1;
  - each frame is 4774 cycles.
- `BAUD_RATE`=1_000_000 (DIV=50):
  - each bit is exactly 50 cycles;
  - the decoder at matching baud reports 0xC3.
